// File: rtl/shreg_acq_ctrl.sv
// Acquisition sequencer for the unrolled sample shift register: clear, delay, shift N beats, hold window.
// Optional sticky start-while-busy flag enabled by defining SHREG_ACQ_CTRL_STARTERR_EN.
module shreg_acq_ctrl #(
    parameter int DWIDTH = 14,
    parameter int UNR    = 4,
    parameter int BUFLEN = 40,
    parameter int CWIDTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [CWIDTH-1:0] delay_cycles,
    input  logic [CWIDTH-1:0] acq_beats,
    output logic              shreg_clr,
    output logic              shift_en,
    output logic              stream_valid,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              busy,
    output logic              done,
    output logic [CWIDTH-1:0] beat_cnt,
    output logic              start_err
);

    localparam int FILL = (BUFLEN + UNR - 1) / UNR;
    localparam logic [CWIDTH-1:0] FILL_C = CWIDTH'(FILL);
    localparam logic [CWIDTH-1:0] ONE_C  = CWIDTH'(1);

    // Parameter sanity guard; the sample width itself only matters to the shift register.
    if (DWIDTH < 1 || UNR < 1 || BUFLEN < 1) begin : g_bad_param
        $error("shreg_acq_ctrl: DWIDTH, UNR and BUFLEN must be positive");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CWIDTH-1:0] dcnt_q, dcnt_d;
    logic [CWIDTH-1:0] n_q, n_d;
    logic [CWIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CWIDTH-1:0] beat_inc_s;
    logic              shreg_clr_q, shreg_clr_d;
    logic              shift_en_q, shift_en_d;
    logic              stream_valid_q, stream_valid_d;
    logic              win_valid_q, win_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next state and next registered outputs; outputs describe the state being entered.
    always_comb begin
        state_d        = state_q;
        dcnt_d         = dcnt_q;
        n_d            = n_q;
        beat_cnt_d     = beat_cnt_q;
        shreg_clr_d    = 1'b0;
        shift_en_d     = 1'b0;
        stream_valid_d = 1'b0;
        win_valid_d    = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        beat_inc_s     = beat_cnt_q + ONE_C;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_DELAY;
                    dcnt_d      = delay_cycles;
                    n_d         = (acq_beats < FILL_C) ? FILL_C : acq_beats;
                    beat_cnt_d  = '0;
                    shreg_clr_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DELAY: begin
                busy_d = 1'b1;
                if (dcnt_q == '0) begin
                    state_d    = S_SHIFT;
                    shift_en_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - ONE_C;
                end
            end
            S_SHIFT: begin
                busy_d     = 1'b1;
                beat_cnt_d = beat_inc_s;
                if (beat_inc_s == n_q) begin
                    state_d     = S_HOLD;
                    win_valid_d = 1'b1;
                end else begin
                    shift_en_d     = 1'b1;
                    stream_valid_d = (beat_inc_s >= FILL_C);
                end
            end
            S_HOLD: begin
                // win_valid_q is the registered copy, so ready never feeds valid combinationally.
                if (win_valid_q && win_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d      = 1'b1;
                    win_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            beat_cnt_d     = beat_cnt_q;
            shreg_clr_d    = 1'b0;
            shift_en_d     = 1'b0;
            stream_valid_d = 1'b0;
            win_valid_d    = 1'b0;
            busy_d         = 1'b0;
            done_d         = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            dcnt_q         <= '0;
            n_q            <= '0;
            beat_cnt_q     <= '0;
            shreg_clr_q    <= 1'b0;
            shift_en_q     <= 1'b0;
            stream_valid_q <= 1'b0;
            win_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dcnt_q         <= dcnt_d;
            n_q            <= n_d;
            beat_cnt_q     <= beat_cnt_d;
            shreg_clr_q    <= shreg_clr_d;
            shift_en_q     <= shift_en_d;
            stream_valid_q <= stream_valid_d;
            win_valid_q    <= win_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

`ifdef SHREG_ACQ_CTRL_STARTERR_EN
    logic start_err_q, start_err_d;

    // Sticky start-while-busy flag, cleared by the next accepted start.
    always_comb begin
        start_err_d = start_err_q;
        if ((state_q == S_IDLE) && start && !abort) begin
            start_err_d = 1'b0;
        end else if (start && busy_q) begin
            start_err_d = 1'b1;
        end else begin
            start_err_d = start_err_q;
        end
    end

    // Start-error flag register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_err_q <= 1'b0;
        end else begin
            start_err_q <= start_err_d;
        end
    end

    assign start_err = start_err_q;
`else
    assign start_err = 1'b0;
`endif

    assign shreg_clr    = shreg_clr_q;
    assign shift_en     = shift_en_q;
    assign stream_valid = stream_valid_q;
    assign win_valid    = win_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_shreg_acq_ctrl.sv
// Self-checking bench for shreg_acq_ctrl: expected output vectors derived from the timing formulas
// are queued as stimulus is driven and compared when the registered outputs appear.
module tb_shreg_acq_ctrl;

    localparam int CW   = 16;
    localparam int FILL = 10;
`ifdef SHREG_ACQ_CTRL_STARTERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] delay_cycles = '0;
    logic [CW-1:0] acq_beats = '0;
    logic          shreg_clr, shift_en, stream_valid, win_valid, busy, done, start_err;
    logic          win_ready = 1'b0;
    logic [CW-1:0] beat_cnt;
    logic [22:0]   obs;

    int n_checks = 0;
    int n_errors = 0;

    shreg_acq_ctrl dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .delay_cycles(delay_cycles), .acq_beats(acq_beats),
        .shreg_clr(shreg_clr), .shift_en(shift_en), .stream_valid(stream_valid),
        .win_valid(win_valid), .win_ready(win_ready), .busy(busy), .done(done),
        .beat_cnt(beat_cnt), .start_err(start_err)
    );

    always #5 CLK = ~CLK;

    assign obs = {shreg_clr, shift_en, stream_valid, win_valid, busy, done, start_err, beat_cnt};

    task automatic check_eq(input string tag, input logic [22:0] got, input logic [22:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got clr/sh/sv/wv/busy/done/err=%b beat=%0d, expected %b beat=%0d",
                     tag, got[22:16], got[15:0], exp[22:16], exp[15:0]);
        end
    endtask

    function automatic int beat_nom(int c, int d, int n);
        if (c < 2 + d) return 0;
        if (c <= 1 + d + n) return c - (2 + d);
        return n;
    endfunction

    // Expected outputs at cycle c for a start sampled at cycle 0.
    function automatic logic [22:0] exp_at(int c, int d, int n, int rdy, int ab, int rs, int es,
                                           bit restart);
        int   hs, h, bc;
        logic clr, sh, sv, wv, bz, dn, er;
        hs = 2 + d + n;
        h  = (rdy > hs) ? rdy : hs;
        er = ERR_EN && (es >= 0) && (c > es) && !(restart && (c >= h + 2));
        if (rs >= 0 && c > rs) return '0;
        if (ab >= 0 && c > ab) begin
            bc = beat_nom(ab, d, n);
            return {6'b0, er, 16'(bc)};
        end
        clr = (c == 1);
        sh  = (c >= 2 + d) && (c <= 1 + d + n);
        sv  = (c >= 2 + d + FILL) && (c <= 1 + d + n);
        wv  = (c >= hs) && (c <= h);
        bz  = (c >= 1) && (c <= h);
        dn  = (c == h + 1);
        bc  = beat_nom(c, d, n);
        if (restart && c >= h + 2) begin
            clr = (c == h + 2);
            sh = 1'b0; sv = 1'b0; wv = 1'b0; dn = 1'b0;
            bz = 1'b1;
            bc = 0;
        end
        return {clr, sh, sv, wv, bz, dn, er, 16'(bc)};
    endfunction

    task automatic run_scn(input string name, input int d, input int beats, input int rdy,
                           input int ab, input int rs, input int es, input bit restart);
        int          n, hs, h, last;
        logic [22:0] sb[$];
        logic [22:0] e;
        n    = (beats < FILL) ? FILL : beats;
        hs   = 2 + d + n;
        h    = (rdy > hs) ? rdy : hs;
        last = restart ? h + 2 : (ab >= 0 ? ab + 4 : (rs >= 0 ? rs + 3 : h + 3));

        RST = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq({name, " reset"}, obs, 23'd0);

        sb.push_back(exp_at(0, d, n, rdy, ab, rs, es, restart));
        for (int c = 0; c <= last; c++) begin
            RST          = (c == rs);
            start        = (c == 0) || (c == es) || (restart && c == h + 1);
            abort        = (c == ab);
            win_ready    = (c >= rdy);
            delay_cycles = (c == 0) ? CW'(d) : CW'($urandom);
            acq_beats    = (c == 0) ? CW'(beats) : CW'($urandom);
            if (sb.size() == 0) begin
                check_eq($sformatf("%s c%0d scoreboard empty", name, c), obs, ~obs);
            end else begin
                e = sb.pop_front();
                check_eq($sformatf("%s c%0d", name, c), obs, e);
            end
            sb.push_back(exp_at(c + 1, d, n, rdy, ab, rs, es, restart));
            @(posedge CLK);
            #1;
        end
        RST = 1'b0; start = 1'b0; abort = 1'b0; win_ready = 1'b0;
    endtask

    initial begin
        #1;
        //      name          D  beats rdy ab  rs  es  restart
        run_scn("nominal",    3, 12,   20, -1, -1, -1, 1'b0);
        run_scn("clamp",      0, 3,    0,  -1, -1, -1, 1'b0);
        run_scn("abort",      3, 12,   20, 8,  -1, -1, 1'b0);
        run_scn("start_busy", 3, 12,   20, -1, -1, 6,  1'b1);
        run_scn("rst_hold",   3, 12,   20, -1, 18, -1, 1'b0);
        run_scn("start_abort",3, 12,   20, 0,  -1, -1, 1'b0);
        run_scn("exact_fill", 1, 10,   13, -1, -1, -1, 1'b0);
        run_scn("late_ready", 2, 15,   30, -1, -1, -1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
